// File: rtl/alu_seq.sv
// alu_seq: integer execute unit. Single-cycle ALU ops plus iterative
// multiply (MUL_BPC multiplier bits per cycle) and restoring divide, behind
// valid/ready request and response ports.
module alu_seq #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [4:0]       req_op_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_p_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_BPC - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_V    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES     = '1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    typedef struct packed {
        logic [4:0]       op;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
    } req_t;

    function automatic logic [XLEN-1:0] alu_fn(input logic [4:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [SW-1:0]   sh;
        logic [XLEN-1:0] r;
        sh = b[SW-1:0];
        case (op)
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            5'd5:    r = a << sh;
            5'd6:    r = a >> sh;
            5'd7:    r = $unsigned($signed(a) >>> sh);
            5'd8:    r = XLEN'(a < b);
            5'd9:    r = XLEN'(a >= b);
            5'd10:   r = XLEN'($signed(a) < $signed(b));
            5'd11:   r = XLEN'($signed(a) >= $signed(b));
            5'd12:   r = XLEN'(a == b);
            5'd13:   r = XLEN'(a != b);
            5'd14:   r = b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    req_t   req;
    state_t state_q, state_d, tgt;
    logic   accept, is_mul, is_div, div_sgn, div_rem, div_zero, div_ovf;
    logic   mul_a_neg, mul_b_neg, div_a_neg, div_b_neg;
    logic [XLEN-1:0] fast_p;

    logic [4:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, mcand_q, acc_nxt, mul_full;
    logic [XLEN-1:0]   mplier_q, rem_q, quo_q, dvs_q;
    logic              qneg_q, rneg_q;
    logic [XLEN:0]     rem_sh, diff;
    logic [XLEN-1:0]   rem_nxt, quo_nxt, mul_p, div_p;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_p_q;
    logic [TAG_W-1:0]  resp_tag_q;

    assign req       = {req_op_i, req_a_i, req_b_i, req_tag_i};
    assign req_ready_o = rst_ni & ~flush_i &
                         ((state_q == S_IDLE) | ((state_q == S_DONE) & resp_ready_i));
    assign accept    = req_valid_i & req_ready_o;
    assign is_mul    = (req.op[4:2] == 3'b100);
    assign is_div    = (req.op[4:2] == 3'b101);
    assign div_sgn   = ~req.op[0];
    assign div_rem   = req.op[1];
    assign div_zero  = (req.b == '0);
    assign div_ovf   = div_sgn & (req.a == MIN_V) & (req.b == ONES);
    assign mul_a_neg = (req.op[1:0] != 2'b11) & req.a[XLEN-1];
    assign mul_b_neg = ~req.op[1] & req.b[XLEN-1];
    assign div_a_neg = div_sgn & req.a[XLEN-1];
    assign div_b_neg = div_sgn & req.b[XLEN-1];

    // Divide special cases resolve at accept time, so they share the ALU path.
    assign fast_p = !is_div  ? alu_fn(req.op, req.a, req.b) :
                    div_zero ? (div_rem ? req.a : ONES) :
                               (div_rem ? '0 : MIN_V);
    assign tgt    = is_mul ? S_MUL : (is_div & ~(div_zero | div_ovf)) ? S_DIV : S_DONE;

    // Shift-add step on magnitudes: retire MUL_BPC multiplier bits.
    always_comb begin
        acc_nxt = acc_q;
        for (int j = 0; j < MUL_BPC; j++)
            if (mplier_q[j]) acc_nxt = acc_nxt + (mcand_q << j);
    end

    assign mul_full = qneg_q ? -acc_nxt : acc_nxt;
    assign mul_p    = (op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, dvs_q};
    assign rem_nxt  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nxt  = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign div_p    = op_q[1] ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = tgt;
            S_MUL:   if (cnt_q == MUL_LAST) state_d = S_DONE;
            S_DIV:   if (cnt_q == DIV_LAST) state_d = S_DONE;
            S_DONE:  if (resp_ready_i) state_d = accept ? tgt : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Operand capture, iteration datapath and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q <= '0; tag_q <= '0; cnt_q <= '0;
            acc_q <= '0; mcand_q <= '0; mplier_q <= '0;
            rem_q <= '0; quo_q <= '0; dvs_q <= '0;
            qneg_q <= 1'b0; rneg_q <= 1'b0;
            resp_valid_q <= 1'b0; resp_p_q <= '0; resp_tag_q <= '0;
        end else if (flush_i) begin
            resp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= req.op;
                tag_q    <= req.tag;
                cnt_q    <= '0;
                acc_q    <= '0;
                mcand_q  <= {{XLEN{1'b0}}, mag(req.a, mul_a_neg)};
                mplier_q <= mag(req.b, mul_b_neg);
                rem_q    <= '0;
                quo_q    <= mag(req.a, div_a_neg);
                dvs_q    <= mag(req.b, div_b_neg);
                qneg_q   <= is_mul ? (mul_a_neg ^ mul_b_neg) : (div_a_neg ^ div_b_neg);
                rneg_q   <= div_a_neg;
                if (tgt == S_DONE) begin
                    resp_valid_q <= 1'b1;
                    resp_p_q     <= fast_p;
                    resp_tag_q   <= req.tag;
                end else begin
                    resp_valid_q <= 1'b0;
                end
            end else if ((state_q == S_DONE) && resp_ready_i) begin
                resp_valid_q <= 1'b0;
            end
            if (state_q == S_MUL) begin
                acc_q    <= acc_nxt;
                mcand_q  <= mcand_q << MUL_BPC;
                mplier_q <= mplier_q >> MUL_BPC;
                cnt_q    <= cnt_q + CW'(1);
                if (cnt_q == MUL_LAST) begin
                    resp_valid_q <= 1'b1;
                    resp_p_q     <= mul_p;
                    resp_tag_q   <= tag_q;
                end
            end
            if (state_q == S_DIV) begin
                if (cnt_q != DIV_LAST) begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    // Sign fix cycle.
                    resp_valid_q <= 1'b1;
                    resp_p_q     <= div_p;
                    resp_tag_q   <= tag_q;
                end
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_p_o     = resp_p_q;
    assign resp_tag_o   = resp_tag_q;
    assign busy_o       = (state_q == S_MUL) | (state_q == S_DIV);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors with literal expectations plus a
// per-cycle scoreboard driven by an arithmetic reference model.
module tb_alu_seq;
    localparam int XLEN    = 32;
    localparam int MUL_BPC = 2;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
    logic             req_valid_i = 1'b0, resp_ready_i = 1'b1;
    logic             req_ready_o, resp_valid_o, busy_o;
    logic [4:0]       req_op_i = '0;
    logic [XLEN-1:0]  req_a_i = '0, req_b_i = '0, resp_p_o;
    logic [TAG_W-1:0] req_tag_i = '0, resp_tag_o;
    int total = 0, bad = 0, cyc = 0;

    alu_seq #(.XLEN(XLEN), .MUL_BPC(MUL_BPC), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_p_o(resp_p_o), .resp_tag_o(resp_tag_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, pr;
        logic [31:0] r;
        sa = $signed(a); sb = $signed(b);
        ua = {32'b0, a}; ub = {32'b0, b};
        pr = 0;
        case (op)
            1:  r = a - b;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = a << b[4:0];
            6:  r = a >> b[4:0];
            7:  r = $unsigned($signed(a) >>> b[4:0]);
            8:  r = (a < b) ? 1 : 0;
            9:  r = (a >= b) ? 1 : 0;
            10: r = (sa < sb) ? 1 : 0;
            11: r = (sa >= sb) ? 1 : 0;
            12: r = (a == b) ? 1 : 0;
            13: r = (a != b) ? 1 : 0;
            14: r = b;
            16: begin pr = sa * sb; r = pr[31:0];  end
            17: begin pr = sa * sb; r = pr[63:32]; end
            18: begin pr = sa * ub; r = pr[63:32]; end
            19: begin pr = ua * ub; r = pr[63:32]; end
            20: if (b == 0) r = '1; else begin pr = sa / sb; r = pr[31:0]; end
            21: r = (b == 0) ? '1 : a / b;
            22: if (b == 0) r = a; else begin pr = sa % sb; r = pr[31:0]; end
            23: r = (b == 0) ? a : a % b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // Edges after the accept edge until the result shows.
    function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 16 && op <= 19) return XLEN / MUL_BPC;
        if (op >= 20 && op <= 23) begin
            if (b == 0) return 0;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return XLEN + 1;
        end
        return 0;
    endfunction

    typedef struct { logic [31:0] p; logic [4:0] tag; int due; bit iter; } exp_t;
    exp_t sb[$];

    // Per-cycle scoreboard compare.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (!rst_ni) begin
            sb.delete();
            chk("rst_valid", resp_valid_o, 0);
            chk("rst_p", resp_p_o, 0);
            chk("rst_tag", resp_tag_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_ready", req_ready_o, 0);
        end else begin
            if (sb.size() == 0) begin
                chk("idle_valid", resp_valid_o, 0);
                chk("idle_busy", busy_o, 0);
            end else if (cyc < sb[0].due) begin
                chk("pend_valid", resp_valid_o, 0);
                chk("pend_busy", busy_o, sb[0].iter);
            end else begin
                chk("sb_valid", resp_valid_o, 1);
                chk("sb_p", resp_p_o, sb[0].p);
                chk("sb_tag", resp_tag_o, sb[0].tag);
                chk("sb_busy", busy_o, 0);
                if (resp_ready_i || flush_i) void'(sb.pop_front());
            end
            if (flush_i) sb.delete();
            else if (req_valid_i && req_ready_o) begin
                e.p    = model(req_op_i, req_a_i, req_b_i);
                e.tag  = req_tag_i;
                e.iter = lat_of(req_op_i, req_a_i, req_b_i) > 0;
                e.due  = cyc + 1 + lat_of(req_op_i, req_a_i, req_b_i);
                sb.push_back(e);
            end
        end
    end

    // Present a request until accepted; returns one cycle after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int waits);
        req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = tag; req_valid_i = 1'b1;
        waits = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (req_ready_o) begin waits = i; break; end
        end
        if (waits < 0) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_a_i = $urandom; req_b_i = $urandom;
        req_tag_i = 5'($urandom); req_op_i = 5'($urandom);
    endtask

    task automatic wait_resp(input logic [31:0] exp, input logic [4:0] tag, input int exp_lat,
                             input string name);
        int n, nb;
        n = -1; nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid_o) begin n = i; break; end
            if (busy_o) nb++;
        end
        chk({name, "_lat"}, n, exp_lat);
        chk({name, "_p"}, resp_p_o, exp);
        chk({name, "_tag"}, resp_tag_o, tag);
        chk({name, "_busy"}, nb, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int exp_lat,
                          input string name);
        int w;
        issue(op, a, b, tag, w);
        wait_resp(exp, tag, exp_lat, name);
    endtask

    logic [4:0]  s_op [8] = '{5'd1, 5'd7, 5'd10, 5'd8, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [31:0] s_a  [8] = '{32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd5, 32'd7, 32'd7, 32'd0};
    logic [31:0] s_b  [8] = '{32'd5, 32'd4, 32'd1, 32'd1, 32'hFFFF_FFFD, 32'd7, 32'd7,
                              32'hABCD_0000};
    logic [31:0] s_r  [8] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'd0, 32'd1, 32'd1, 32'd0,
                              32'hABCD_0000};

    initial begin
        int w, spur;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready_o, 1);
        @(posedge clk); #1;

        run_op(5'd0, 32'd5, 32'd7, 5'd3, 32'd12, 0, "add");

        // Back-to-back single-cycle stream.
        for (int i = 0; i < 8; i++) begin
            req_op_i = s_op[i]; req_a_i = s_a[i]; req_b_i = s_b[i];
            req_tag_i = 5'(i); req_valid_i = 1'b1;
            @(negedge clk);
            chk("stream_ready", req_ready_o, 1);
            if (i > 0) begin
                chk("stream_valid", resp_valid_o, 1);
                chk("stream_p", resp_p_o, s_r[i-1]);
            end
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("stream_valid_last", resp_valid_o, 1);
        chk("stream_p_last", resp_p_o, s_r[7]);
        @(posedge clk); #1;

        run_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 16, "mulh");
        run_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 16, "mulhu");
        run_op(5'd18, 32'hFFFF_FFFE, 32'd3,         5'd3, 32'hFFFF_FFFF, 16, "mulhsu");
        run_op(5'd16, 32'hFFFF_FFFE, 32'd3,         5'd4, 32'hFFFF_FFFA, 16, "mul");
        run_op(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 16, "mulhsu_ub");
        run_op(5'd19, 32'h8000_0000, 32'd2,         5'd6, 32'h0000_0001, 16, "mulhu_2");

        run_op(5'd20, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33, "div");
        run_op(5'd22, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, "rem");
        run_op(5'd20, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 33, "div_negb");
        run_op(5'd21, 32'hFFFF_FFFF, 32'd10, 5'd10, 32'h1999_9999, 33, "divu");
        run_op(5'd23, 32'hFFFF_FFFF, 32'd10, 5'd11, 32'd5, 33, "remu");
        run_op(5'd21, 32'd7, 32'd0, 5'd12, 32'hFFFF_FFFF, 0, "divu_by0");
        run_op(5'd22, 32'd7, 32'd0, 5'd13, 32'd7, 0, "rem_by0");
        run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0, "div_ovf");
        run_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 0, "rem_ovf");

        run_op(5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd16, 32'hF000_F000, 0, "and");
        run_op(5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd17, 32'hFFF0_FFF0, 0, "or");
        run_op(5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd18, 32'h0FF0_0FF0, 0, "xor");
        run_op(5'd5,  32'd1, 32'h23, 5'd19, 32'd8, 0, "sll_wrap");
        run_op(5'd6,  32'h8000_0000, 32'd31, 5'd20, 32'd1, 0, "srl");
        run_op(5'd9,  32'd1, 32'hFFFF_FFFF, 5'd21, 32'd0, 0, "sgeu");
        run_op(5'd15, 32'd2, 32'd3, 5'd22, 32'd5, 0, "op15");
        run_op(5'd31, 32'd10, 32'd20, 5'd23, 32'd30, 0, "op31");

        // Backpressure: result held, no new request accepted.
        resp_ready_i = 1'b0;
        issue(5'd20, 32'd100, 32'd7, 5'd9, w);
        wait_resp(32'd14, 5'd9, 33, "bp_div");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid_o, 1);
            chk("bp_p", resp_p_o, 32'd14);
            chk("bp_tag", resp_tag_o, 5'd9);
            chk("bp_ready", req_ready_o, 0);
        end
        @(posedge clk); #1;
        resp_ready_i = 1'b1;
        issue(5'd0, 32'd1, 32'd2, 5'd4, w);
        chk("bp_same_cycle", w, 1);
        wait_resp(32'd3, 5'd4, 0, "bp_add");

        // Flush during divide iteration.
        issue(5'd20, 32'd1000, 32'd3, 5'd1, w);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        req_valid_i = 1'b1; req_op_i = 5'd0; req_a_i = 32'd1; req_b_i = 32'd1;
        @(negedge clk);
        chk("fl_ready", req_ready_o, 0);
        @(posedge clk); #1;
        flush_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        chk("fl_busy", busy_o, 0);
        chk("fl_valid", resp_valid_o, 0);
        chk("fl_idle_ready", req_ready_o, 1);
        spur = 0;
        repeat (40) begin @(negedge clk); if (resp_valid_o) spur++; end
        chk("fl_no_resp", spur, 0);
        @(posedge clk); #1;

        // Reset in the middle of a multiply.
        run_op(5'd0, 32'd1, 32'd1, 5'd6, 32'd2, 0, "pre_rst");
        issue(5'd17, 32'd123, 32'd456, 5'd7, w);
        repeat (5) @(negedge clk);
        @(posedge clk); #3;
        rst_ni = 1'b0;
        #1;
        chk("mrst_valid", resp_valid_o, 0);
        chk("mrst_p", resp_p_o, 0);
        chk("mrst_tag", resp_tag_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_ready", req_ready_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        spur = 0;
        repeat (40) begin @(negedge clk); if (resp_valid_o) spur++; end
        chk("mrst_no_resp", spur, 0);
        @(posedge clk); #1;
        run_op(5'd0, 32'd20, 32'd22, 5'd2, 32'd42, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
